// File: rtl/fetch_buffer_if.sv
// Fetch-to-decode buffer bus: fetch group in, decode packet out, dequeue count,
// flush and occupancy. The buffer itself connects through the slave modport.
interface fetch_buffer_if #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0]       in_valid;
  logic [WIDTH-1:0][31:0] in_inst;
  logic [WIDTH-1:0][31:0] in_pc;
  logic                   in_ready;
  logic [WIDTH-1:0]       out_valid;
  logic [WIDTH-1:0][31:0] out_inst;
  logic [WIDTH-1:0][31:0] out_pc;
  logic [2:0]             deq_cnt;
  logic                   flush;
  logic [CW-1:0]          count;

  modport master (
    output in_valid, in_inst, in_pc, deq_cnt, flush,
    input  in_ready, out_valid, out_inst, out_pc, count
  );

  modport slave (
    input  in_valid, in_inst, in_pc, deq_cnt, flush,
    output in_ready, out_valid, out_inst, out_pc, count
  );
endinterface

// File: rtl/fetch_buffer.sv
// Circular instruction buffer between fetch and decode with compacting enqueue.
// Optional FETCH_BUF_PERF_EN adds stall/empty cycle counters.
module fetch_buffer #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  fetch_buffer_if.slave   bus
`ifdef FETCH_BUF_PERF_EN
  ,
  output logic [31:0]     perf_stall_cyc,
  output logic [31:0]     perf_empty_cyc
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0]   inst_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];

  logic          in_ready;
  logic          accept;
  logic [CW-1:0] enq_n;
  logic [CW-1:0] enq_eff;
  logic [CW-1:0] deq_n;
  logic [WIDTH-1:0] wr_en;
  logic [PW-1:0] wr_addr [WIDTH];
  logic [PW-1:0] rd_addr [WIDTH];

  // Space check uses registered occupancy only, so fetch never sees a comb path.
  assign in_ready = (CW'(DEPTH) - count_q) >= CW'(WIDTH);
  assign accept   = in_ready && !bus.flush;

  // NOTE: every always_comb output gets a default before any conditional
  // assignment, otherwise synthesis infers a latch.
  always_comb begin
    enq_n = '0;
    wr_en = '0;
    for (int k = 0; k < WIDTH; k++) begin
      wr_addr[k] = tail_q + PW'(enq_n);
      if (bus.in_valid[k]) begin
        wr_en[k] = accept;
        enq_n    = enq_n + CW'(1);
      end
    end
    enq_eff = accept ? enq_n : '0;
  end

  always_comb begin
    deq_n = CW'(bus.deq_cnt);
    if (deq_n > count_q)     deq_n = count_q;
    if (deq_n > CW'(WIDTH))  deq_n = CW'(WIDTH);
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PW'(deq_n);
      tail_d  = tail_q + PW'(enq_eff);
      count_d = count_q + enq_eff - deq_n;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: entry storage is deliberately not reset; out_valid masks stale data.
  always_ff @(posedge clk) begin
    for (int k = 0; k < WIDTH; k++) begin
      if (wr_en[k]) begin
        inst_mem[wr_addr[k]] <= bus.in_inst[k];
        pc_mem[wr_addr[k]]   <= bus.in_pc[k];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < WIDTH; k++) begin
      rd_addr[k]       = head_q + PW'(k);
      bus.out_valid[k] = count_q > CW'(k);
      bus.out_inst[k]  = inst_mem[rd_addr[k]];
      bus.out_pc[k]    = pc_mem[rd_addr[k]];
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.count    = count_q;

`ifdef FETCH_BUF_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_empty_q, perf_empty_d;

  // Counters survive flush and wrap naturally at 2^32.
  always_comb begin
    perf_stall_d = perf_stall_q + 32'((|bus.in_valid) && !in_ready);
    perf_empty_d = perf_empty_q + 32'(count_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_empty_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_empty_q <= perf_empty_d;
    end
  end

  assign perf_stall_cyc = perf_stall_q;
  assign perf_empty_cyc = perf_empty_q;
`endif
endmodule

// File: tb/tb_fetch_buffer.sv
// Scoreboard bench for fetch_buffer: a queue-based reference model predicts each
// cycle's outputs, a separate monitor compares them. Define FETCH_BUF_PERF_EN for perf checks.
module tb_fetch_buffer;
  localparam int DEPTH = 16;
  localparam int WIDTH = 4;

  typedef struct packed {
    logic [4:0]        cnt;
    logic              rdy;
    logic [3:0]        vld;
    logic [3:0][31:0]  pc;
    logic [3:0][31:0]  inst;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_buffer_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

`ifdef FETCH_BUF_PERF_EN
  logic [31:0] perf_stall_cyc;
  logic [31:0] perf_empty_cyc;
`endif

  fetch_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef FETCH_BUF_PERF_EN
    ,
    .perf_stall_cyc (perf_stall_cyc),
    .perf_empty_cyc (perf_empty_cyc)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [63:0] model_q[$];   // {pc, inst} in program order
  exp_t        exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_expect();
    exp_t e;
    int sz;
    e  = '0;
    sz = model_q.size();
    e.cnt = 5'(sz);
    e.rdy = (DEPTH - sz) >= WIDTH;
    for (int k = 0; k < WIDTH; k++) begin
      if (k < sz) begin
        e.vld[k]  = 1'b1;
        e.pc[k]   = model_q[k][63:32];
        e.inst[k] = model_q[k][31:0];
      end
    end
    exp_q.push_back(e);
  endtask

  // Called just after a rising edge: drive one cycle, predict, advance.
  task automatic step(input logic [3:0] v, input logic [31:0] base,
                      input logic [2:0] d, input logic f);
    int sz;
    int dn;
    bit rdy;
    bus.in_valid = v;
    for (int k = 0; k < WIDTH; k++) begin
      bus.in_pc[k]   = base + 32'(4 * k);
      bus.in_inst[k] = $urandom;
    end
    bus.deq_cnt = d;
    bus.flush   = f;
    push_expect();
    sz  = model_q.size();
    rdy = (DEPTH - sz) >= WIDTH;
    if (f) begin
      model_q.delete();
    end else begin
      dn = int'(d);
      if (dn > sz)    dn = sz;
      if (dn > WIDTH) dn = WIDTH;
      repeat (dn) void'(model_q.pop_front());
      if (rdy)
        for (int k = 0; k < WIDTH; k++)
          if (v[k]) model_q.push_back({bus.in_pc[k], bus.in_inst[k]});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("count",     32'(bus.count),     32'(e.cnt));
        check("in_ready",  32'(bus.in_ready),  32'(e.rdy));
        check("out_valid", 32'(bus.out_valid), 32'(e.vld));
        for (int k = 0; k < WIDTH; k++) begin
          if (e.vld[k]) begin
            check($sformatf("out_pc[%0d]", k),   bus.out_pc[k],   e.pc[k]);
            check($sformatf("out_inst[%0d]", k), bus.out_inst[k], e.inst[k]);
          end
        end
      end
    end
  end

  initial begin : stimulus
    logic [31:0] base;
`ifdef FETCH_BUF_PERF_EN
    logic [31:0] s0;
    logic [31:0] e0;
`endif
    rst_n        = 1'b0;
    bus.in_valid = '0;
    bus.in_inst  = '0;
    bus.in_pc    = '0;
    bus.deq_cnt  = '0;
    bus.flush    = 1'b0;
    #1;
    check("rst_count",     32'(bus.count),     32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Full group into an empty buffer
    step(4'b1111, 32'h100, 3'd0, 1'b0);
    check("full_grp_count", 32'(bus.count),     32'd4);
    check("full_grp_valid", 32'(bus.out_valid), 32'hF);
    check("full_grp_pc0",   bus.out_pc[0],      32'h100);
    check("full_grp_pc3",   bus.out_pc[3],      32'h10C);
    step(4'b0000, 32'h0, 3'd4, 1'b0);

    // Sparse group compacts to the head
    step(4'b1010, 32'h200, 3'd0, 1'b0);
    check("sparse_count", 32'(bus.count),     32'd2);
    check("sparse_pc0",   bus.out_pc[0],      32'h204);
    check("sparse_pc1",   bus.out_pc[1],      32'h20C);
    check("sparse_valid", 32'(bus.out_valid), 32'h3);
    step(4'b0000, 32'h0, 3'd4, 1'b0);

    // Backpressure near full
    for (int i = 0; i < 3; i++) step(4'b1111, 32'h300 + 32'(16 * i), 3'd0, 1'b0);
    step(4'b0001, 32'h330, 3'd0, 1'b0);
    check("bp_count13", 32'(bus.count),    32'd13);
    check("bp_ready0",  32'(bus.in_ready), 32'd0);
    step(4'b1111, 32'h340, 3'd0, 1'b0);
    check("bp_ignored", 32'(bus.count), 32'd13);
    step(4'b1111, 32'h350, 3'd1, 1'b0);
    check("bp_count12", 32'(bus.count),    32'd12);
    check("bp_ready1",  32'(bus.in_ready), 32'd1);
    repeat (3) step(4'b0000, 32'h0, 3'd4, 1'b0);

    // Steady state at count 6 with pointer wrap
    step(4'b1111, 32'h400, 3'd0, 1'b0);
    step(4'b0011, 32'h410, 3'd0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(4'b1111, 32'h420 + 32'(16 * i), 3'd4, 1'b0);
      check("steady_count", 32'(bus.count), 32'd6);
    end

    // Flush beats simultaneous enqueue and dequeue
    step(4'b0000, 32'h0, 3'd0, 1'b1);
    step(4'b1111, 32'h600, 3'd0, 1'b0);
    step(4'b1111, 32'h610, 3'd0, 1'b0);
    step(4'b0001, 32'h620, 3'd0, 1'b0);
    check("pre_flush_count", 32'(bus.count), 32'd9);
    step(4'b1111, 32'h700, 3'd3, 1'b1);
    check("flush_count", 32'(bus.count),     32'd0);
    check("flush_valid", 32'(bus.out_valid), 32'd0);
    check("flush_ready", 32'(bus.in_ready),  32'd1);
    step(4'b0011, 32'h800, 3'd0, 1'b0);
    check("post_flush_pc0", bus.out_pc[0], 32'h800);

`ifdef FETCH_BUF_PERF_EN
    step(4'b0000, 32'h0, 3'd0, 1'b1);
    for (int i = 0; i < 4; i++) step(4'b1111, 32'hA00 + 32'(16 * i), 3'd0, 1'b0);
    s0 = perf_stall_cyc;
    repeat (5) step(4'b1111, 32'hB00, 3'd0, 1'b0);
    check("perf_stall_delta", perf_stall_cyc - s0, 32'd5);
    step(4'b0000, 32'h0, 3'd0, 1'b1);
    e0 = perf_empty_cyc;
    repeat (3) step(4'b0000, 32'h0, 3'd0, 1'b0);
    check("perf_empty_delta", perf_empty_cyc - e0, 32'd3);
`endif

    // Asynchronous reset mid-operation
    step(4'b1111, 32'h880, 3'd0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_count", 32'(bus.count),     32'd0);
    check("midrst_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_ready", 32'(bus.in_ready),  32'd1);
    model_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(4'b0100, 32'h900, 3'd0, 1'b0);
    check("midrst_first_pc", bus.out_pc[0], 32'h908);

    // Randomized traffic
    base = 32'h1000;
    for (int i = 0; i < 400; i++) begin
      step(4'($urandom), base, 3'($urandom_range(0, 5)), ($urandom_range(0, 19) == 0));
      base = base + 32'd16;
    end

    step(4'b0000, 32'h0, 3'd0, 1'b0);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
